// File: rtl/ps2_link_pkg.sv
// Shared types for the PS/2 link layer: FSM states, FIFO entry layout and
// the odd-parity helper used on both the receive and transmit paths.
package ps2_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_TX_INHIBIT,
    ST_TX_START,
    ST_TX_BITS,
    ST_TX_ACK,
    ST_ACK_HOLD
  } ps2_link_state_t;

  typedef struct packed {
    logic       error;
    logic [7:0] data;
  } ps2_fifo_entry_t;

  // Parity bit that makes the nine transmitted bits contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_link_fifo.sv
// Show-ahead receive FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate count. A push arriving while full
// is still accepted when the head is popped in the same cycle.
module ps2_link_fifo
  import ps2_link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  ps2_fifo_entry_t push_data,
  input  logic            pop,
  output ps2_fifo_entry_t head,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);

  ps2_fifo_entry_t mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            wr_en;
  logic            rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both wrap naturally through the extra MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are only visible through head when non-empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_link.sv
// PS/2 link layer: clock filter, device-to-host receiver into a FIFO and
// host-to-device command transmitter with acknowledge reporting.
// Optional watchdog on stalled frames: define PS2_LINK_TIMEOUT_EN.
//
// state         | meaning
// ST_IDLE       | waiting for a start bit or a command
// ST_RX         | shifting in data, parity and stop bits
// ST_TX_INHIBIT | holding the clock low to claim the bus
// ST_TX_START   | data low, clock released (start bit)
// ST_TX_BITS    | driving data/parity on each fall, then releasing for stop
// ST_TX_ACK     | sampling the device acknowledge on the next fall
// ST_ACK_HOLD   | presenting the command result until accepted
module ps2_link
  import ps2_link_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FILTER_LEN = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_out,
  output logic       ps2_data_out,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       command_valid,
  output logic       command_ready,
  input  logic [7:0] command_byte,
  output logic       command_ack_valid,
  input  logic       command_ack_ready,
  output logic       command_ack_error,
  output logic       scan_code_valid,
  input  logic       scan_code_ready,
  output logic [7:0] scan_code_byte,
  output logic       scan_code_error,
  output logic       rx_overflow
);

  localparam int INHIBIT_CYC = CLK_HZ / 10000;
  localparam int TW          = $clog2(INHIBIT_CYC + 1);
  localparam int FW          = $clog2(FILTER_LEN + 1);
  localparam int WD_CYC      = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int WW          = $clog2(WD_CYC + 1);

  ps2_link_state_t state, state_n;
  logic [FW-1:0]   filt_cnt;
  logic            filt_clk, fall, fall_d;
  logic [3:0]      bit_cnt;
  logic [7:0]      rx_shift;
  logic            rx_par;
  logic [8:0]      tx_bits;
  logic [TW-1:0]   timer;
  logic            clk_oe_n, data_oe_n, ack_err_n, latch_cmd, push_req, wd_expire;
  logic            fifo_full, fifo_empty, pop;
  ps2_fifo_entry_t push_data, head;

  assign ps2_clk_out  = 1'b0;
  assign ps2_data_out = 1'b0;

  // Clock filter: level flips after FILTER_LEN consecutive samples of the new level.
  assign fall_d = filt_clk && !ps2_clk_in && (filt_cnt == FW'(FILTER_LEN - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= fall_d;
      if (ps2_clk_in == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= ps2_clk_in;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

`ifdef PS2_LINK_TIMEOUT_EN
  logic          watch;
  logic [WW-1:0] wd_cnt;
  assign watch     = state inside {ST_RX, ST_TX_START, ST_TX_BITS, ST_TX_ACK};
  assign wd_expire = watch && !fall && (wd_cnt == '0);
  // Watchdog down-counter: reloads on every fall and outside watched states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                wd_cnt <= WW'(WD_CYC - 1);
    else if (!watch || fall)  wd_cnt <= WW'(WD_CYC - 1);
    else if (wd_cnt != '0)    wd_cnt <= wd_cnt - 1'b1;
  end
`else
  logic unused_wd;
  assign unused_wd = ^WW'(WD_CYC);
  assign wd_expire = 1'b0;
`endif

  assign push_data.data  = rx_shift;
  assign push_data.error = (odd_parity(rx_shift) != rx_par) || !ps2_data_in;
  assign pop             = scan_code_valid && scan_code_ready;
  assign rx_overflow     = push_req && fifo_full && !pop;

  // Next state, next line drives and command result.
  always_comb begin
    state_n   = state;
    clk_oe_n  = 1'b0;
    data_oe_n = 1'b0;
    ack_err_n = command_ack_error;
    latch_cmd = 1'b0;
    push_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall && !ps2_data_in) begin
          state_n = ST_RX;
        end else if (command_valid && command_ready) begin
          state_n   = ST_TX_INHIBIT;
          clk_oe_n  = 1'b1;
          latch_cmd = 1'b1;
        end
      end
      ST_RX: begin
        if (fall && bit_cnt == 4'd10) begin
          state_n  = ST_IDLE;
          push_req = 1'b1;
        end else if (wd_expire) begin
          state_n = ST_IDLE;
        end
      end
      ST_TX_INHIBIT: begin
        if (timer == '0) begin
          state_n   = ST_TX_START;
          data_oe_n = 1'b1;
        end else begin
          clk_oe_n = 1'b1;
        end
      end
      ST_TX_START: begin
        if (wd_expire) begin
          state_n   = ST_ACK_HOLD;
          ack_err_n = 1'b1;
        end else begin
          state_n   = ST_TX_BITS;
          data_oe_n = 1'b1;
        end
      end
      ST_TX_BITS: begin
        data_oe_n = ps2_data_oe;
        if (wd_expire) begin
          state_n   = ST_ACK_HOLD;
          data_oe_n = 1'b0;
          ack_err_n = 1'b1;
        end else if (fall) begin
          data_oe_n = (bit_cnt < 4'd9) ? !tx_bits[bit_cnt] : 1'b0;
          if (bit_cnt == 4'd10) state_n = ST_TX_ACK;
        end
      end
      ST_TX_ACK: begin
        if (fall) begin
          state_n   = ST_ACK_HOLD;
          ack_err_n = ps2_data_in;
        end else if (wd_expire) begin
          state_n   = ST_ACK_HOLD;
          ack_err_n = 1'b1;
        end
      end
      ST_ACK_HOLD: begin
        if (command_ack_ready) begin
          state_n   = ST_IDLE;
          ack_err_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, registered line drives, bit counting and shift registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      ps2_clk_oe        <= 1'b0;
      ps2_data_oe       <= 1'b0;
      command_ready     <= 1'b0;
      command_ack_error <= 1'b0;
      bit_cnt           <= '0;
      rx_shift          <= '0;
      rx_par            <= 1'b0;
      tx_bits           <= '0;
      timer             <= '0;
    end else begin
      state             <= state_n;
      ps2_clk_oe        <= clk_oe_n;
      ps2_data_oe       <= data_oe_n;
      command_ready     <= (state_n == ST_IDLE) && !fall_d;
      command_ack_error <= ack_err_n;
      if (state_n != state)  bit_cnt <= (state_n == ST_RX) ? 4'd1 : 4'd0;
      else if (fall)         bit_cnt <= bit_cnt + 1'b1;
      if (state == ST_RX && fall) begin
        if (bit_cnt <= 4'd8) rx_shift <= {ps2_data_in, rx_shift[7:1]};
        if (bit_cnt == 4'd9) rx_par <= ps2_data_in;
      end
      if (latch_cmd) begin
        tx_bits <= {odd_parity(command_byte), command_byte};
        timer   <= TW'(INHIBIT_CYC - 1);
      end else if (state == ST_TX_INHIBIT && timer != '0) begin
        timer <= timer - 1'b1;
      end
    end
  end

  assign command_ack_valid = (state == ST_ACK_HOLD);

  ps2_link_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign scan_code_valid = !fifo_empty;
  assign scan_code_byte  = head.data;
  assign scan_code_error = head.error;

endmodule

// File: tb/tb_ps2_link.sv
// Self-checking bench for ps2_link: acts as a PS/2 device on an open-drain
// bus and checks receive, transmit, overflow, glitch rejection and reset.
module tb_ps2_link;

  localparam int CLK_HZ     = 1_000_000;
  localparam int FILTER_LEN = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT_US = 300;
  localparam int INHIBIT    = CLK_HZ / 10000;
  localparam int WD         = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int HALF       = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic ps2_clk_in, ps2_data_in, ps2_clk_out, ps2_data_out, ps2_clk_oe, ps2_data_oe;
  logic command_valid = 1'b0, command_ready;
  logic [7:0] command_byte = 8'h00;
  logic command_ack_valid, command_ack_ready = 1'b0, command_ack_error;
  logic scan_code_valid, scan_code_ready = 1'b0, scan_code_error;
  logic [7:0] scan_code_byte;
  logic rx_overflow;

  int tests = 0;
  int fails = 0;
  int seen_ovf = 0;
  int exp_ovf = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  // Open-drain bus: either side may pull a line low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always @(negedge clk) if (rx_overflow) seen_ovf++;

  ps2_link #(
    .CLK_HZ(CLK_HZ), .FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk(clk), .reset(reset),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .command_valid(command_valid), .command_ready(command_ready), .command_byte(command_byte),
    .command_ack_valid(command_ack_valid), .command_ack_ready(command_ack_ready),
    .command_ack_error(command_ack_error),
    .scan_code_valid(scan_code_valid), .scan_code_ready(scan_code_ready),
    .scan_code_byte(scan_code_byte), .scan_code_error(scan_code_error),
    .rx_overflow(rx_overflow)
  );

  // Parity bit giving an odd count of ones over data plus parity.
  function automatic logic par_bit(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  // Reference receiver: what a correct link stores for a complete frame.
  task automatic model_rx(input logic [7:0] b, input logic par, input logic stp);
    logic err;
    err = (par != par_bit(b)) || !stp;
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({err, b});
    else exp_ovf++;
  endtask

  task automatic dev_pulse();
    @(negedge clk) dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int nbits);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_data = f[i];
      dev_pulse();
    end
    dev_data = 1'b1;
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    @(negedge clk);
    obs = {ps2_clk_oe, ps2_data_oe, ps2_clk_out, ps2_data_out, command_ready, command_ack_valid,
           command_ack_error, scan_code_valid, scan_code_byte, scan_code_error, rx_overflow};
    tests++;
    if (obs !== 18'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (command_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_rise: got %b expected 1", command_ready);
    end
  endtask

  task automatic test_rx_fixed();
    logic [8:0] exp;
    for (int p = 0; p < 2; p++) begin
      send_frame(8'h1C, p[0], 1'b1, 11);
      model_rx(8'h1C, p[0], 1'b1);
      repeat (3) @(negedge clk);
      exp = exp_q.pop_front();
      tests++;
      if ({scan_code_valid, scan_code_error, scan_code_byte} !== {1'b1, exp}) begin
        fails++;
        $display("FAIL rx_1c_par%0d: got v=%b e=%b b=%h expected v=1 e=%b b=%h", p,
                 scan_code_valid, scan_code_error, scan_code_byte, exp[8], exp[7:0]);
      end
      scan_code_ready = 1'b1;
      @(negedge clk) scan_code_ready = 1'b0;
    end
  endtask

  task automatic test_rx_random();
    logic [7:0] b;
    logic par, stp;
    logic [8:0] exp;
    for (int n = 0; n < 6; n++) begin
      b   = 8'($urandom);
      par = par_bit(b) ^ ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 4) != 0);
      send_frame(b, par, stp, 11);
      model_rx(b, par, stp);
      repeat (3) @(negedge clk);
      exp = exp_q.pop_front();
      tests++;
      if ({scan_code_valid, scan_code_error, scan_code_byte} !== {1'b1, exp}) begin
        fails++;
        $display("FAIL rx_random_%0d: got v=%b e=%b b=%h expected v=1 e=%b b=%h", n,
                 scan_code_valid, scan_code_error, scan_code_byte, exp[8], exp[7:0]);
      end
      scan_code_ready = 1'b1;
      @(negedge clk) scan_code_ready = 1'b0;
    end
  endtask

  task automatic test_tx(input logic [7:0] b, input logic ack);
    logic [8:0] txv;
    int cnt;
    logic exp_oe;
    txv = {par_bit(b), b};
    cnt = 0;
    while (!command_ready && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    command_valid = 1'b1;
    command_byte  = b;
    @(negedge clk) command_valid = 1'b0;
    cnt = 0;
    while (ps2_clk_oe && cnt < 10 * INHIBIT) begin
      cnt++;
      @(negedge clk);
    end
    tests++;
    if (cnt != INHIBIT) begin
      fails++;
      $display("FAIL tx_inhibit_len_%h: got %0d cycles expected %0d", b, cnt, INHIBIT);
    end
    tests++;
    if (ps2_data_oe !== 1'b1) begin
      fails++;
      $display("FAIL tx_start_bit_%h: got data_oe=%b expected 1", b, ps2_data_oe);
    end
    repeat (HALF) @(negedge clk);
    for (int p = 1; p <= 11; p++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      exp_oe = (p <= 9) ? !txv[p-1] : 1'b0;
      tests++;
      if (ps2_data_oe !== exp_oe) begin
        fails++;
        $display("FAIL tx_bit_%h_%0d: got data_oe=%b expected %b", b, p, ps2_data_oe, exp_oe);
      end
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_data = ack ? 1'b0 : 1'b1;
    dev_clk  = 1'b0;
    cnt = 0;
    while (!command_ack_valid && cnt < 4 * HALF) begin
      cnt++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    tests++;
    if ({command_ack_valid, command_ack_error} !== {1'b1, !ack}) begin
      fails++;
      $display("FAIL tx_ack_%h: got v=%b e=%b expected v=1 e=%b", b,
               command_ack_valid, command_ack_error, !ack);
    end
    command_ack_ready = 1'b1;
    @(negedge clk) command_ack_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (command_ack_valid !== 1'b0) begin
      fails++;
      $display("FAIL tx_ack_release_%h: got v=%b expected 0", b, command_ack_valid);
    end
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    logic [8:0] exp;
    dev_data = 1'b0;
    @(negedge clk) dev_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (HALF) @(negedge clk);
    tests++;
    if ({command_ready, scan_code_valid} !== 2'b10) begin
      fails++;
      $display("FAIL glitch_idle: got ready=%b valid=%b expected ready=1 valid=0",
               command_ready, scan_code_valid);
    end
    b = 8'($urandom);
    send_frame(b, par_bit(b), 1'b1, 11);
    model_rx(b, par_bit(b), 1'b1);
    repeat (3) @(negedge clk);
    exp = exp_q.pop_front();
    tests++;
    if ({scan_code_valid, scan_code_error, scan_code_byte} !== {1'b1, exp}) begin
      fails++;
      $display("FAIL glitch_next_frame: got v=%b e=%b b=%h expected v=1 e=%b b=%h",
               scan_code_valid, scan_code_error, scan_code_byte, exp[8], exp[7:0]);
    end
    scan_code_ready = 1'b1;
    @(negedge clk) scan_code_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    logic [8:0] exp;
    int ovf_base;
    ovf_base = seen_ovf;
    exp_ovf  = 0;
    for (int n = 0; n < FIFO_DEPTH + 1; n++) begin
      b = 8'($urandom);
      send_frame(b, par_bit(b), 1'b1, 11);
      model_rx(b, par_bit(b), 1'b1);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (seen_ovf - ovf_base != exp_ovf) begin
      fails++;
      $display("FAIL overflow_pulses: got %0d expected %0d", seen_ovf - ovf_base, exp_ovf);
    end
    for (int n = 0; n < FIFO_DEPTH; n++) begin
      exp = exp_q.pop_front();
      tests++;
      if ({scan_code_valid, scan_code_error, scan_code_byte} !== {1'b1, exp}) begin
        fails++;
        $display("FAIL overflow_pop_%0d: got v=%b e=%b b=%h expected v=1 e=%b b=%h", n,
                 scan_code_valid, scan_code_error, scan_code_byte, exp[8], exp[7:0]);
      end
      scan_code_ready = 1'b1;
      @(negedge clk) scan_code_ready = 1'b0;
    end
    tests++;
    if (scan_code_valid !== 1'b0) begin
      fails++;
      $display("FAIL overflow_drained: got valid=%b expected 0", scan_code_valid);
    end
  endtask

`ifdef PS2_LINK_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    send_frame(8'($urandom), 1'b0, 1'b1, 5);
    repeat (WD / 2) @(negedge clk);
    tests++;
    if (command_ready !== 1'b0) begin
      fails++;
      $display("FAIL timeout_rx_busy: got ready=%b expected 0", command_ready);
    end
    repeat (WD) @(negedge clk);
    tests++;
    if ({command_ready, scan_code_valid} !== 2'b10) begin
      fails++;
      $display("FAIL timeout_rx_abort: got ready=%b valid=%b expected ready=1 valid=0",
               command_ready, scan_code_valid);
    end
    command_valid = 1'b1;
    command_byte  = 8'($urandom);
    @(negedge clk) command_valid = 1'b0;
    cnt = 0;
    while (ps2_clk_oe && cnt < 10 * INHIBIT) begin
      cnt++;
      @(negedge clk);
    end
    repeat (HALF) @(negedge clk);
    for (int p = 0; p < 5; p++) dev_pulse();
    cnt = 0;
    while (!command_ack_valid && cnt < 3 * WD) begin
      cnt++;
      @(negedge clk);
    end
    tests++;
    if ({command_ack_valid, command_ack_error, ps2_data_oe, ps2_clk_oe} !== 4'b1100) begin
      fails++;
      $display("FAIL timeout_tx: got v=%b e=%b doe=%b coe=%b expected v=1 e=1 doe=0 coe=0",
               command_ack_valid, command_ack_error, ps2_data_oe, ps2_clk_oe);
    end
    command_ack_ready = 1'b1;
    @(negedge clk) command_ack_ready = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask
`endif

  task automatic test_reset_midframe();
    command_valid = 1'b1;
    command_byte  = 8'($urandom);
    @(negedge clk) command_valid = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (ps2_clk_oe !== 1'b1) begin
      fails++;
      $display("FAIL midframe_inhibit: got clk_oe=%b expected 1", ps2_clk_oe);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({ps2_clk_oe, ps2_data_oe, command_ready, command_ack_valid} !== 4'b0000) begin
      fails++;
      $display("FAIL midframe_release: got coe=%b doe=%b rdy=%b ackv=%b expected all 0",
               ps2_clk_oe, ps2_data_oe, command_ready, command_ack_valid);
    end
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({command_ready, ps2_clk_oe, scan_code_valid} !== 3'b100) begin
      fails++;
      $display("FAIL midframe_recover: got rdy=%b coe=%b valid=%b expected 1 0 0",
               command_ready, ps2_clk_oe, scan_code_valid);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_rx_fixed();
    test_rx_random();
    test_tx(8'hED, 1'b1);
    test_tx(8'($urandom), 1'b0);
    test_tx(8'($urandom), 1'b1);
    test_glitch();
    test_overflow();
`ifdef PS2_LINK_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete, %0d tests run", tests);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ps2_link.md
# ps2_link

Parametrised PS/2 link layer replacing the fixed single-port protocol engine between `ps2_physical` and the keyboard state/key-code logic. Filters the PS/2 clock, receives device-to-host frames into a FIFO, and sends host-to-device command bytes. Checks framing and parity, and reports device acknowledge. An optional watchdog aborts stalled frames.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency; sets the inhibit and timeout cycle counts.
- `FILTER_LEN`, 8, number of consecutive equal samples needed before the filtered PS/2 clock changes level.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, ≥2.
- `TIMEOUT_US`, 2000, watchdog period in µs.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_clk_in`, `ps2_data_in`  in  1  pin levels, already synchronised to `clk`.
- `ps2_clk_out`, `ps2_data_out`  out  1  drive value; always 0.
- `ps2_clk_oe`, `ps2_data_oe`  out  1  1 = pull the line low.
- `command_valid`  in  1, `command_ready`  out  1, `command_byte`  in  8: host-to-device byte.
- `command_ack_valid`  out  1, `command_ack_ready`  in  1, `command_ack_error`  out  1: result of a command.
- `scan_code_valid`  out  1, `scan_code_ready`  in  1, `scan_code_byte`  out  8, `scan_code_error`  out  1: FIFO head.
- `rx_overflow`  out  1: one-cycle pulse when a received frame is dropped because the FIFO is full.

## Operation
- **Clock filter:** the filtered clock starts at 1. It changes level only after `FILTER_LEN` consecutive samples of the new level. A falling edge (`fall`) is a filtered 1→0 transition.
- **State machine:** IDLE, RX, TX_INHIBIT, TX_START, TX_BITS, TX_ACK, ACK_HOLD.
- **IDLE:**
  - `fall` with `ps2_data_in`=0 → RX, bit count 1.
  - `command_valid & command_ready` → latch the byte, → TX_INHIBIT.
  - If both occur in the same cycle, RX wins and `command_ready` is 0 in that cycle.
- **RX:**
  - Sample `ps2_data_in` on each `fall`: 8 data bits LSB first, then parity, then stop.
  - After the stop bit, push `{error, byte}` into the FIFO and return to IDLE.
  - `error` = parity not odd, or stop bit = 0.
  - A FIFO push is never dropped for a simultaneous pop.
- **TX_INHIBIT:** `ps2_clk_oe`=1 for `CLK_HZ/10000` cycles (100 µs).
- **TX_START:**
  - `ps2_data_oe`=1 and `ps2_clk_oe`=0 for one cycle, then → TX_BITS.
  - Odd parity is computed at latch time.
- **TX_BITS:**
  - On each `fall`, drive the next bit: 8 data bits LSB first, then parity.
  - Bit value 0 → `ps2_data_oe`=1; bit value 1 → `ps2_data_oe`=0.
  - After parity, release data for the stop bit.
  - On the 11th `fall` → TX_ACK.
- **TX_ACK:**
  - On the next `fall`, `ps2_data_in`=0 means ACK; 1 means NACK (error=1).
  - → ACK_HOLD.
- **ACK_HOLD:**
  - `command_ack_valid`=1, held stable until `command_ack_ready`; then → IDLE.
  - Receive is blocked meanwhile; the keyboard retries inhibited frames.
- **Handshakes:**
  - `command_ready` = (state == IDLE) and no `fall` in that cycle.
  - `scan_code_*` show the FIFO head; pop on `scan_code_valid & scan_code_ready`.
- **Full FIFO:**
  - The frame is discarded and `rx_overflow` pulses on the stop-bit cycle.
  - FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits wide and wrap naturally.

## Timing
- **Reset values:**
  - All `*_oe`=0; `*_out`=0.
  - `command_ready`=0; `command_ack_valid`=0; `command_ack_error`=0.
  - `scan_code_valid`=0; `scan_code_byte`=0; `scan_code_error`=0; `rx_overflow`=0.
  - FIFO empty, filtered clock=1, state IDLE.
- `command_ready` is registered; it rises on the first `clk` after reset deasserts.
- **Filter latency:** a pin edge produces `fall` `FILTER_LEN` cycles later.
- `scan_code_valid` rises 1 cycle after the stop-bit `fall`.
- `command_ack_valid` rises 1 cycle after the ack `fall`.
- **Reset mid-frame:** all lines are released immediately and any partial frame is lost.

## Configuration
- **`PS2_LINK_TIMEOUT_EN` defined:**
  - A watchdog counter of `CLK_HZ/1_000_000*TIMEOUT_US` cycles runs in RX, TX_START, TX_BITS and TX_ACK.
  - It reloads on every `fall`.
  - On expiry in RX: discard the frame, release both lines, → IDLE.
  - On expiry in TX states: release both lines, → ACK_HOLD with error=1.
- **Undefined:** no counter; a stalled frame waits until reset.

## Structure
- Package `ps2_link_pkg`:
  - state enum `ps2_link_state_t`
  - `odd_parity` function
  - FIFO entry struct `{logic error; logic [7:0] data;}`
- Sub-module `ps2_link_fifo`: synchronous FIFO parametrised by `DEPTH`, with show-ahead output and full/empty flags.

## Test plan
- **Receive 0x1C** (data bits 0,0,1,1,1,0,0,0, parity 0, stop 1) → `scan_code_byte`=0x1C, `scan_code_error`=0.
- **Receive 0x1C with parity 1** → `scan_code_byte`=0x1C, `scan_code_error`=1.
- **Send 0xED, device ACKs:**
  - `ps2_clk_oe` is high for exactly `CLK_HZ/10000` cycles.
  - Data bits 1,0,1,1,0,1,1,1 are driven, then parity 1.
  - `command_ack_valid`=1 with `command_ack_error`=0.
- **`FIFO_DEPTH`=4, 5 frames, `scan_code_ready`=0** → 4 entries retained, one `rx_overflow` pulse, entries popped in arrival order.
- **Glitch:** a PS/2 clock low pulse of `FILTER_LEN-1` cycles → no bit sampled.
- **Timeout (`PS2_LINK_TIMEOUT_EN` defined):** device stops after 5 bits → return to IDLE after the timeout period, no FIFO push; the same stall in TX → `command_ack_error`=1.
